id_hazard_scoreboard: RTL and testbench

- Parametrised successor to the decode-stage hazard logic. It replaces the fixed EX/MA compare with a per-register scoreboard.
- Tracks producer latency and age, generates the load-use stall, and selects the forwarding source (EX/MA/WB/regfile) per operand.
- Owns the halt-drain/debug state machine. Sits in ID, between the fetch handshake and the operand muxes.

---
 rtl/id_scoreboard_pkg.sv | 19 +
 rtl/id_hazard_scoreboard_if.sv | 42 ++++
 rtl/scoreboard_entry.sv | 54 +++++
 rtl/id_hazard_scoreboard.sv | 105 ++++++++++
 tb/tb_id_hazard_scoreboard.sv | 193 +++++++++++++++++++
 5 files changed

// File: rtl/id_scoreboard_pkg.sv
// Shared encodings for the ID-stage hazard scoreboard: FSM states,
// forwarding-source codes and nominal producer latencies.
package id_scoreboard_pkg;

    typedef enum logic [1:0] {
        ST_RUN    = 2'b00,
        ST_DRAIN  = 2'b01,
        ST_HALTED = 2'b10
    } state_e;

    localparam int unsigned FWD_RF = 0;
    localparam int unsigned FWD_EX = 1;
    localparam int unsigned FWD_MA = 2;
    localparam int unsigned FWD_WB = 3;

    localparam int unsigned LAT_ALU  = 1;
    localparam int unsigned LAT_LOAD = 2;

endpackage

// File: rtl/id_hazard_scoreboard_if.sv
// Issue/hazard bundle between the ID stage control and the scoreboard.
interface id_hazard_scoreboard_if #(
    parameter int unsigned N_REGISTERS       = 32,
    parameter int unsigned NB_ADDR_REGISTERS = 5,
    parameter int unsigned NB_LAT            = 2,
    parameter int unsigned NB_FWD_SEL        = 2,
    parameter int unsigned NB_COUNT          = 6
);
    logic                         i_issue_valid;
    logic                         i_issue_reg_write;
    logic [NB_ADDR_REGISTERS-1:0] i_issue_rd_num;
    logic [NB_LAT-1:0]            i_issue_latency;
    logic [NB_ADDR_REGISTERS-1:0] i_rs_num;
    logic [NB_ADDR_REGISTERS-1:0] i_rt_num;
    logic                         i_rs_used;
    logic                         i_rt_used;
    logic                         i_halt_req;
    logic                         i_resume;
    logic                         o_issue_accept;
    logic                         o_stall;
    logic [NB_FWD_SEL-1:0]        o_fwd_sel_rs;
    logic [NB_FWD_SEL-1:0]        o_fwd_sel_rt;
    logic [N_REGISTERS-1:0]       o_pending_mask;
    logic [NB_COUNT-1:0]          o_busy_count;
    logic [1:0]                   o_state;
    logic                         o_halted;

    modport master (
        output i_issue_valid, i_issue_reg_write, i_issue_rd_num, i_issue_latency,
        output i_rs_num, i_rt_num, i_rs_used, i_rt_used, i_halt_req, i_resume,
        input  o_issue_accept, o_stall, o_fwd_sel_rs, o_fwd_sel_rt,
        input  o_pending_mask, o_busy_count, o_state, o_halted
    );

    modport slave (
        input  i_issue_valid, i_issue_reg_write, i_issue_rd_num, i_issue_latency,
        input  i_rs_num, i_rt_num, i_rs_used, i_rt_used, i_halt_req, i_resume,
        output o_issue_accept, o_stall, o_fwd_sel_rs, o_fwd_sel_rt,
        output o_pending_mask, o_busy_count, o_state, o_halted
    );

endinterface

// File: rtl/scoreboard_entry.sv
// One register's scoreboard slot: age walks EX->MA->WB then retires,
// rem counts down the cycles until the result becomes forwardable.
module scoreboard_entry #(
    parameter int unsigned N_FWD_STAGES = 3,
    parameter int unsigned NB_AGE       = 2,
    parameter int unsigned NB_LAT       = 2
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_clk_en,
    input  logic              i_set,
    input  logic [NB_LAT-1:0] i_set_rem,
    output logic [NB_AGE-1:0] o_age,
    output logic [NB_LAT-1:0] o_rem
);

    logic [NB_AGE-1:0] age_q, age_d;
    logic [NB_LAT-1:0] rem_q, rem_d;

    always_comb begin
        age_d = age_q;
        rem_d = rem_q;
        if (i_clk_en) begin
            // A fresh issue overrides aging so the youngest producer wins.
            if (i_set) begin
                age_d = NB_AGE'(1);
                rem_d = i_set_rem;
            end else begin
                if (age_q == NB_AGE'(N_FWD_STAGES)) begin
                    age_d = '0;
                end else if (age_q != '0) begin
                    age_d = age_q + NB_AGE'(1);
                end
                if (rem_q != '0) begin
                    rem_d = rem_q - NB_LAT'(1);
                end
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            age_q <= '0;
            rem_q <= '0;
        end else begin
            age_q <= age_d;
            rem_q <= rem_d;
        end
    end

    assign o_age = age_q;
    assign o_rem = rem_q;

endmodule

// File: rtl/id_hazard_scoreboard.sv
// ID-stage hazard scoreboard: per-register producer tracking, load-use stall,
// forwarding-source select and the halt/drain/debug state machine.
module id_hazard_scoreboard
    import id_scoreboard_pkg::*;
#(
    parameter int unsigned N_REGISTERS       = 32,
    parameter int unsigned NB_ADDR_REGISTERS = 5,
    parameter int unsigned N_FWD_STAGES      = 3,
    parameter int unsigned MAX_LATENCY       = 3,
    parameter int unsigned NB_LAT            = 2,
    parameter int unsigned NB_FWD_SEL        = 2,
    parameter int unsigned NB_COUNT          = 6
) (
    input  logic                   i_clk,
    input  logic                   i_reset,
    input  logic                   i_clk_en,
    id_hazard_scoreboard_if.slave  bus
);

    logic [NB_FWD_SEL-1:0] age [N_REGISTERS];
    logic [NB_LAT-1:0]     rem [N_REGISTERS];
    logic [N_REGISTERS-1:0] pending;
    logic [NB_COUNT-1:0]   busy;
    logic [NB_LAT-1:0]     set_rem;
    int unsigned           lat_eff;
    logic                  run, rs_hazard, rt_hazard, stall, accept, issue_write;
    state_e                state_q, state_d;

    always_comb begin
        lat_eff = 32'(bus.i_issue_latency);
        if (lat_eff == 0) begin
            lat_eff = LAT_ALU;
        end else if (lat_eff > MAX_LATENCY) begin
            lat_eff = MAX_LATENCY;
        end
        set_rem = NB_LAT'(lat_eff - 1);
    end

    // r0 is hardwired zero: never tracked, always reads from the regfile.
    assign age[0]     = NB_FWD_SEL'(FWD_RF);
    assign rem[0]     = '0;
    assign pending[0] = 1'b0;

    for (genvar r = 1; r < N_REGISTERS; r++) begin : g_entry
        scoreboard_entry #(
            .N_FWD_STAGES (N_FWD_STAGES),
            .NB_AGE       (NB_FWD_SEL),
            .NB_LAT       (NB_LAT)
        ) u_entry (
            .i_clk     (i_clk),
            .i_reset   (i_reset),
            .i_clk_en  (i_clk_en),
            .i_set     (issue_write && (bus.i_issue_rd_num == NB_ADDR_REGISTERS'(r))),
            .i_set_rem (set_rem),
            .o_age     (age[r]),
            .o_rem     (rem[r])
        );
        assign pending[r] = (age[r] != '0);
    end

    assign run       = (state_q == ST_RUN);
    assign rs_hazard = bus.i_rs_used && (bus.i_rs_num != '0) && (rem[bus.i_rs_num] != '0);
    assign rt_hazard = bus.i_rt_used && (bus.i_rt_num != '0) && (rem[bus.i_rt_num] != '0);
    assign stall     = run && bus.i_issue_valid && (rs_hazard || rt_hazard);
    assign accept    = run && bus.i_issue_valid && !stall;
    // The HALT instruction itself leaves ID but never claims a destination.
    assign issue_write = accept && bus.i_issue_reg_write && !bus.i_halt_req;

    always_comb begin
        busy = '0;
        for (int i = 0; i < N_REGISTERS; i++) begin
            busy = busy + NB_COUNT'(pending[i]);
        end
    end

    always_comb begin
        state_d = state_q;
        if (i_clk_en) begin
            case (state_q)
                ST_RUN:    if (accept && bus.i_halt_req) state_d = ST_DRAIN;
                ST_DRAIN:  if (pending == '0) state_d = ST_HALTED;
                ST_HALTED: if (bus.i_resume) state_d = ST_RUN;
                default:   state_d = ST_RUN;
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            state_q <= ST_RUN;
        end else begin
            state_q <= state_d;
        end
    end

    assign bus.o_stall        = stall;
    assign bus.o_issue_accept = accept;
    assign bus.o_fwd_sel_rs   = age[bus.i_rs_num];
    assign bus.o_fwd_sel_rt   = age[bus.i_rt_num];
    assign bus.o_pending_mask = pending;
    assign bus.o_busy_count   = busy;
    assign bus.o_state        = state_q;
    assign bus.o_halted       = (state_q == ST_HALTED);

endmodule

// File: tb/tb_id_hazard_scoreboard.sv
// Directed bench for id_hazard_scoreboard: vector table plus drain/reset sequences.
module tb_id_hazard_scoreboard;
    import id_scoreboard_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    logic clk_en;
    int   total = 0;
    int   bad = 0;

    always #5 clk = ~clk;

    id_hazard_scoreboard_if bus ();

    id_hazard_scoreboard u_dut (
        .i_clk    (clk),
        .i_reset  (rst_n),
        .i_clk_en (clk_en),
        .bus      (bus)
    );

    typedef struct {
        logic        en, valid, wr;
        logic [4:0]  rd;
        logic [1:0]  lat;
        logic [4:0]  rs;
        logic        rsu;
        logic [4:0]  rt;
        logic        rtu;
        logic        stall, acc;
        logic [1:0]  fs, ft;
        logic [31:0] mask;
        logic [5:0]  busy;
    } vec_t;

    vec_t vecs[$];

    function automatic logic [31:0] b(input int r);
        return 32'h1 << r;
    endfunction

    function automatic vec_t mk(input logic en, valid, wr, input int rd, lat, rs,
                                input logic rsu, input int rt, input logic rtu,
                                input logic stall, acc, input int fs, ft,
                                input logic [31:0] mask, input int busy);
        vec_t v;
        v.en = en; v.valid = valid; v.wr = wr; v.rd = 5'(rd); v.lat = 2'(lat);
        v.rs = 5'(rs); v.rsu = rsu; v.rt = 5'(rt); v.rtu = rtu;
        v.stall = stall; v.acc = acc; v.fs = 2'(fs); v.ft = 2'(ft);
        v.mask = mask; v.busy = 6'(busy);
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic idle();
        clk_en = 1'b1;
        bus.i_issue_valid = 1'b0; bus.i_issue_reg_write = 1'b0;
        bus.i_issue_rd_num = '0;  bus.i_issue_latency = '0;
        bus.i_rs_num = '0; bus.i_rt_num = '0; bus.i_rs_used = 1'b0; bus.i_rt_used = 1'b0;
        bus.i_halt_req = 1'b0; bus.i_resume = 1'b0;
    endtask

    task automatic issue(input int rd, input int lat);
        bus.i_issue_valid = 1'b1; bus.i_issue_reg_write = 1'b1;
        bus.i_issue_rd_num = 5'(rd); bus.i_issue_latency = 2'(lat);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_fsm(input string tag, input state_e st, input logic halted,
                           input logic acc, input logic [31:0] mask);
        #3;
        check({tag, ".state"}, 32'(bus.o_state), 32'(st));
        check({tag, ".halted"}, 32'(bus.o_halted), 32'(halted));
        check({tag, ".accept"}, 32'(bus.o_issue_accept), 32'(acc));
        check({tag, ".mask"}, bus.o_pending_mask, mask);
    endtask

    initial begin
        idle();
        rst_n = 1'b0;
        #2;
        check("rst.mask", bus.o_pending_mask, 32'h0);
        check("rst.state", 32'(bus.o_state), 32'(ST_RUN));
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;

        //          en v wr rd lat rs u rt u | st ac fs ft mask busy
        vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0, 0));
        vecs.push_back(mk(1, 1, 1, 5, 1, 0, 0, 0, 0, 0, 1, 0, 0, 32'h0, 0));
        vecs.push_back(mk(1, 1, 0, 0, 0, 5, 1, 0, 0, 0, 1, 1, 0, b(5), 1));
        vecs.push_back(mk(1, 1, 0, 0, 0, 0, 0, 5, 1, 0, 1, 0, 2, b(5), 1));
        vecs.push_back(mk(1, 1, 0, 0, 0, 0, 0, 5, 1, 0, 1, 0, 3, b(5), 1));
        vecs.push_back(mk(1, 1, 0, 0, 0, 0, 0, 5, 1, 0, 1, 0, 0, 32'h0, 0));
        vecs.push_back(mk(1, 1, 1, 8, 2, 0, 0, 0, 0, 0, 1, 0, 0, 32'h0, 0));
        vecs.push_back(mk(1, 1, 0, 0, 0, 0, 0, 8, 1, 1, 0, 0, 1, b(8), 1));
        vecs.push_back(mk(1, 1, 0, 0, 0, 0, 0, 8, 1, 0, 1, 0, 2, b(8), 1));
        vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 8, 1, 0, 0, 0, 3, b(8), 1));
        vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 8, 1, 0, 0, 0, 0, 32'h0, 0));
        vecs.push_back(mk(1, 1, 1, 0, 2, 0, 0, 0, 0, 0, 1, 0, 0, 32'h0, 0));
        vecs.push_back(mk(1, 1, 0, 0, 0, 0, 1, 0, 1, 0, 1, 0, 0, 32'h0, 0));
        vecs.push_back(mk(1, 1, 1, 3, 2, 0, 0, 0, 0, 0, 1, 0, 0, 32'h0, 0));
        vecs.push_back(mk(1, 1, 1, 3, 1, 0, 0, 0, 0, 0, 1, 0, 0, b(3), 1));
        vecs.push_back(mk(1, 1, 0, 0, 0, 3, 1, 0, 0, 0, 1, 1, 0, b(3), 1));
        vecs.push_back(mk(1, 0, 0, 0, 0, 3, 0, 0, 0, 0, 0, 2, 0, b(3), 1));
        vecs.push_back(mk(1, 0, 0, 0, 0, 3, 0, 0, 0, 0, 0, 3, 0, b(3), 1));
        vecs.push_back(mk(1, 0, 0, 0, 0, 3, 0, 0, 0, 0, 0, 0, 0, 32'h0, 0));
        vecs.push_back(mk(1, 1, 1, 7, 0, 0, 0, 0, 0, 0, 1, 0, 0, 32'h0, 0));
        vecs.push_back(mk(1, 1, 0, 0, 0, 7, 1, 0, 0, 0, 1, 1, 0, b(7), 1));
        vecs.push_back(mk(1, 1, 1, 9, 3, 0, 0, 0, 0, 0, 1, 0, 0, b(7), 1));
        vecs.push_back(mk(1, 1, 0, 0, 0, 9, 1, 7, 1, 1, 0, 1, 3, b(7) | b(9), 2));
        vecs.push_back(mk(1, 1, 0, 0, 0, 9, 1, 0, 0, 1, 0, 2, 0, b(9), 1));
        vecs.push_back(mk(1, 1, 0, 0, 0, 9, 1, 0, 0, 0, 1, 3, 0, b(9), 1));
        vecs.push_back(mk(0, 1, 1, 10, 1, 0, 0, 0, 0, 0, 1, 0, 0, 32'h0, 0));
        vecs.push_back(mk(1, 0, 0, 0, 0, 10, 1, 0, 0, 0, 0, 0, 0, 32'h0, 0));

        foreach (vecs[i]) begin
            idle();
            clk_en = vecs[i].en;
            bus.i_issue_valid = vecs[i].valid; bus.i_issue_reg_write = vecs[i].wr;
            bus.i_issue_rd_num = vecs[i].rd;   bus.i_issue_latency = vecs[i].lat;
            bus.i_rs_num = vecs[i].rs; bus.i_rs_used = vecs[i].rsu;
            bus.i_rt_num = vecs[i].rt; bus.i_rt_used = vecs[i].rtu;
            #3;
            check($sformatf("v%0d.stall", i), 32'(bus.o_stall), 32'(vecs[i].stall));
            check($sformatf("v%0d.accept", i), 32'(bus.o_issue_accept), 32'(vecs[i].acc));
            check($sformatf("v%0d.fwd_rs", i), 32'(bus.o_fwd_sel_rs), 32'(vecs[i].fs));
            check($sformatf("v%0d.fwd_rt", i), 32'(bus.o_fwd_sel_rt), 32'(vecs[i].ft));
            check($sformatf("v%0d.mask", i), bus.o_pending_mask, vecs[i].mask);
            check($sformatf("v%0d.busy", i), 32'(bus.o_busy_count), 32'(vecs[i].busy));
            check($sformatf("v%0d.state", i), 32'(bus.o_state), 32'(ST_RUN));
            tick();
        end

        // Halt drain behind a load, with a clock-enable gap mid-drain.
        idle(); issue(4, 2);
        chk_fsm("drain.c1", ST_RUN, 1'b0, 1'b1, 32'h0); tick();
        idle(); issue(12, 1); bus.i_halt_req = 1'b1;
        chk_fsm("drain.c2", ST_RUN, 1'b0, 1'b1, b(4)); tick();
        idle(); bus.i_issue_valid = 1'b1; bus.i_rs_num = 5'd4; bus.i_rs_used = 1'b1;
        bus.i_resume = 1'b1;
        chk_fsm("drain.c3", ST_DRAIN, 1'b0, 1'b0, b(4));
        check("drain.c3.stall", 32'(bus.o_stall), 32'h0); tick();
        idle(); clk_en = 1'b0; bus.i_issue_valid = 1'b1;
        chk_fsm("drain.c4", ST_DRAIN, 1'b0, 1'b0, b(4)); tick();
        idle(); clk_en = 1'b0; bus.i_issue_valid = 1'b1;
        chk_fsm("drain.c5", ST_DRAIN, 1'b0, 1'b0, b(4)); tick();
        idle(); bus.i_issue_valid = 1'b1;
        chk_fsm("drain.c6", ST_DRAIN, 1'b0, 1'b0, b(4)); tick();
        idle(); bus.i_issue_valid = 1'b1;
        chk_fsm("drain.c7", ST_DRAIN, 1'b0, 1'b0, 32'h0); tick();
        idle(); bus.i_issue_valid = 1'b1; bus.i_halt_req = 1'b1;
        chk_fsm("drain.c8", ST_HALTED, 1'b1, 1'b0, 32'h0); tick();
        idle(); bus.i_issue_valid = 1'b1; bus.i_resume = 1'b1;
        chk_fsm("drain.c9", ST_HALTED, 1'b1, 1'b0, 32'h0); tick();
        idle(); bus.i_issue_valid = 1'b1;
        chk_fsm("drain.c10", ST_RUN, 1'b0, 1'b1, 32'h0); tick();

        // Asynchronous reset between edges while draining two producers.
        idle(); issue(6, 2); tick();
        idle(); issue(11, 1); tick();
        idle(); bus.i_issue_valid = 1'b1; bus.i_halt_req = 1'b1;
        chk_fsm("areset.halt", ST_RUN, 1'b0, 1'b1, b(6) | b(11)); tick();
        idle();
        chk_fsm("areset.pre", ST_DRAIN, 1'b0, 1'b0, b(6) | b(11));
        check("areset.pre.busy", 32'(bus.o_busy_count), 32'd2);
        rst_n = 1'b0;
        #1;
        check("areset.mask", bus.o_pending_mask, 32'h0);
        check("areset.busy", 32'(bus.o_busy_count), 32'h0);
        check("areset.state", 32'(bus.o_state), 32'(ST_RUN));
        check("areset.halted", 32'(bus.o_halted), 32'h0);
        tick();
        rst_n = 1'b1;
        idle(); bus.i_issue_valid = 1'b1;
        chk_fsm("areset.post", ST_RUN, 1'b0, 1'b1, 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
